ps2_kbd_frontend: RTL and testbench

- PS/2 keyboard front end: deserialises PS/2 frames into an 8-deep scan-code FIFO with a ready/nextdata_n pop handshake and an overflow flag.
- Also provides a registered scan-code to ASCII lookup that honours Shift and Caps Lock.
- Sits between the board PS/2 pins and the key-tracking state machine, which pops codes, tracks make/break (0xF0) and feeds the current key back for ASCII translation.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_ascii_rom.sv | 91 +++++++++
 rtl/ps2_kbd_frontend.sv | 91 +++++++++
 tb/tb_ps2_kbd_frontend.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam int CAPS_BIT  = 1;
  localparam int SHIFT_BIT = 0;

  // start=0, stop=1, odd parity over d0..d7 plus the parity bit
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return !f[0] && f[FRAME_BITS-1] && (^f[FRAME_BITS-2:1]);
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Scan-code set 2 to ASCII translation, registered, honouring Shift and Caps Lock.
module ps2_ascii_rom
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] key,
  input  logic [1:0] mode,
  output logic [7:0] ascii
);

  logic [7:0] w_lo;
  logic [7:0] w_hi;
  logic       w_letter;
  logic       w_upper;
  logic [7:0] r_ascii;

  always_comb begin
    w_lo     = 8'h00;
    w_hi     = 8'h00;
    w_letter = 1'b0;
    case (key)
      8'h1C: begin w_lo = "a"; w_letter = 1'b1; end
      8'h32: begin w_lo = "b"; w_letter = 1'b1; end
      8'h21: begin w_lo = "c"; w_letter = 1'b1; end
      8'h23: begin w_lo = "d"; w_letter = 1'b1; end
      8'h24: begin w_lo = "e"; w_letter = 1'b1; end
      8'h2B: begin w_lo = "f"; w_letter = 1'b1; end
      8'h34: begin w_lo = "g"; w_letter = 1'b1; end
      8'h33: begin w_lo = "h"; w_letter = 1'b1; end
      8'h43: begin w_lo = "i"; w_letter = 1'b1; end
      8'h3B: begin w_lo = "j"; w_letter = 1'b1; end
      8'h42: begin w_lo = "k"; w_letter = 1'b1; end
      8'h4B: begin w_lo = "l"; w_letter = 1'b1; end
      8'h3A: begin w_lo = "m"; w_letter = 1'b1; end
      8'h31: begin w_lo = "n"; w_letter = 1'b1; end
      8'h44: begin w_lo = "o"; w_letter = 1'b1; end
      8'h4D: begin w_lo = "p"; w_letter = 1'b1; end
      8'h15: begin w_lo = "q"; w_letter = 1'b1; end
      8'h2D: begin w_lo = "r"; w_letter = 1'b1; end
      8'h1B: begin w_lo = "s"; w_letter = 1'b1; end
      8'h2C: begin w_lo = "t"; w_letter = 1'b1; end
      8'h3C: begin w_lo = "u"; w_letter = 1'b1; end
      8'h2A: begin w_lo = "v"; w_letter = 1'b1; end
      8'h1D: begin w_lo = "w"; w_letter = 1'b1; end
      8'h22: begin w_lo = "x"; w_letter = 1'b1; end
      8'h35: begin w_lo = "y"; w_letter = 1'b1; end
      8'h1A: begin w_lo = "z"; w_letter = 1'b1; end
      8'h45: begin w_lo = "0"; w_hi = ")"; end
      8'h16: begin w_lo = "1"; w_hi = "!"; end
      8'h1E: begin w_lo = "2"; w_hi = "@"; end
      8'h26: begin w_lo = "3"; w_hi = "#"; end
      8'h25: begin w_lo = "4"; w_hi = "$"; end
      8'h2E: begin w_lo = "5"; w_hi = "%"; end
      8'h36: begin w_lo = "6"; w_hi = "^"; end
      8'h3D: begin w_lo = "7"; w_hi = "&"; end
      8'h3E: begin w_lo = "8"; w_hi = "*"; end
      8'h46: begin w_lo = "9"; w_hi = "("; end
      8'h4E: begin w_lo = "-"; w_hi = "_"; end
      8'h55: begin w_lo = "="; w_hi = "+"; end
      8'h54: begin w_lo = "["; w_hi = "{"; end
      8'h5B: begin w_lo = "]"; w_hi = "}"; end
      8'h5D: begin w_lo = 8'h5C; w_hi = 8'h7C; end
      8'h4C: begin w_lo = ";"; w_hi = ":"; end
      8'h52: begin w_lo = 8'h27; w_hi = 8'h22; end
      8'h41: begin w_lo = ","; w_hi = "<"; end
      8'h49: begin w_lo = "."; w_hi = ">"; end
      8'h4A: begin w_lo = "/"; w_hi = "?"; end
      8'h0E: begin w_lo = 8'h60; w_hi = 8'h7E; end
      8'h29: begin w_lo = 8'h20; w_hi = 8'h20; end
      8'h5A: begin w_lo = 8'h0D; w_hi = 8'h0D; end
      8'h66: begin w_lo = 8'h08; w_hi = 8'h08; end
      8'h0D: begin w_lo = 8'h09; w_hi = 8'h09; end
      8'h76: begin w_lo = 8'h1B; w_hi = 8'h1B; end
      BREAK_CODE, EXT_CODE: begin w_lo = 8'h00; w_hi = 8'h00; end
      default: begin w_lo = 8'h00; w_hi = 8'h00; end
    endcase
    if (w_letter) w_hi = w_lo - 8'h20;
  end

  // Caps Lock only affects letters; it inverts the effect of Shift on them.
  assign w_upper = w_letter ? (mode[SHIFT_BIT] ^ mode[CAPS_BIT]) : mode[SHIFT_BIT];

  always_ff @(posedge clk) begin
    if (clr) r_ascii <= 8'h00;
    else     r_ascii <= w_upper ? w_hi : w_lo;
  end

  assign ascii = r_ascii;

endmodule

// File: rtl/ps2_kbd_frontend.sv
// PS/2 receiver feeding a scan-code FIFO with pop handshake, plus the ASCII lookup.
module ps2_kbd_frontend
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       sampling,
  input  logic [7:0] key,
  input  logic [1:0] mode,
  output logic [7:0] ascii
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0]  r_sync;
  logic [3:0]              r_cnt;
  logic [FRAME_BITS-2:0]   r_shift;
  logic [7:0]              r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic                    r_overflow;

  logic                    w_fall;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_full;
  logic                    w_ready;
  logic                    w_push;
  logic                    w_pop;
  logic [PW-1:0]           w_wptr_nxt;
  logic [FRAME_BITS-1:0]   w_frame;

  assign w_fall     = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];
  assign w_last     = w_fall && (r_cnt == 4'(FRAME_BITS-1));
  // The stop bit is still on the pin when the final edge is seen.
  assign w_frame    = {ps2_data, r_shift};
  assign w_valid    = w_last && frame_ok(w_frame);
  assign w_wptr_nxt = r_wptr + 1'b1;
  assign w_full     = (w_wptr_nxt == r_rptr);
  assign w_ready    = (r_rptr != r_wptr);
  assign w_push     = w_valid & ~w_full;
  assign w_pop      = ~nextdata_n & w_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync     <= '0;
      r_cnt      <= 4'd0;
      r_shift    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ps2_clk};
      if (w_fall) begin
        r_shift <= {ps2_data, r_shift[FRAME_BITS-2:1]};
        r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
      end
      if (w_push) begin
        r_mem[r_wptr] <= w_frame[8:1];
        r_wptr        <= w_wptr_nxt;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_valid && w_full) r_overflow <= 1'b1;
      else if (w_pop)        r_overflow <= 1'b0;
    end
  end

  assign data     = r_mem[r_rptr];
  assign ready    = w_ready;
  assign overflow = r_overflow;
  assign sampling = w_fall;

  ps2_ascii_rom u_ascii_rom (
    .clk   (clk),
    .clr   (clr),
    .key   (key),
    .mode  (mode),
    .ascii (ascii)
  );

endmodule

// File: tb/tb_ps2_kbd_frontend.sv
// Self-checking bench: ASCII vector table plus scoreboarded PS/2 frame sequences.
module tb_ps2_kbd_frontend;

  logic       clk = 1'b0;
  logic       clr;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       sampling;
  logic [7:0] key;
  logic [1:0] mode;
  logic [7:0] ascii;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic       model_ovf;
  int         frame_samples;

  always #5 clk = ~clk;

  ps2_kbd_frontend dut (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .sampling   (sampling),
    .key        (key),
    .mode       (mode),
    .ascii      (ascii)
  );

  typedef struct {
    logic [7:0] k;
    logic [1:0] m;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (sampling) frame_samples++;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input string nm);
    logic par;
    logic good;
    par  = ~(^code) ^ bad_par;
    good = !bad_par;
    frame_samples = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (5) @(negedge clk);
    if (good) begin
      if (exp_q.size() < 7) exp_q.push_back(code);
      else model_ovf = 1'b1;
    end
    chk({nm, " samples"}, 8'(frame_samples), 8'd11);
    chk({nm, " ready"}, {7'd0, ready}, {7'd0, exp_q.size() != 0});
    chk({nm, " overflow"}, {7'd0, overflow}, {7'd0, model_ovf});
    if (exp_q.size() != 0) chk({nm, " head"}, data, exp_q[0]);
  endtask

  task automatic pop_chk(input string nm);
    logic [7:0] e;
    @(negedge clk);
    chk({nm, " ready"}, {7'd0, ready}, 8'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, data %h", nm, data);
    end else begin
      e = exp_q.pop_front();
      chk({nm, " data"}, data, e);
    end
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    model_ovf  = 1'b0;
    chk({nm, " overflow after pop"}, {7'd0, overflow}, 8'd0);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev;
    clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    key = 8'h00; mode = 2'b00; model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", {7'd0, ready}, 8'd0);
    chk("reset data", data, 8'h00);
    chk("reset overflow", {7'd0, overflow}, 8'd0);
    chk("reset sampling", {7'd0, sampling}, 8'd0);
    chk("reset ascii", ascii, 8'h00);
    clr = 1'b0;
    repeat (4) @(negedge clk);

    vecs = '{
      '{8'h1C, 2'b00, 8'h61}, '{8'h1C, 2'b01, 8'h41}, '{8'h1C, 2'b10, 8'h41},
      '{8'h1C, 2'b11, 8'h61}, '{8'h16, 2'b10, 8'h31}, '{8'h16, 2'b01, 8'h21},
      '{8'hF0, 2'b00, 8'h00}, '{8'h1A, 2'b10, 8'h5A}, '{8'hF0, 2'b01, 8'h00},
      '{8'h4E, 2'b01, 8'h5F}, '{8'hF0, 2'b10, 8'h00}, '{8'h4E, 2'b10, 8'h2D},
      '{8'hF0, 2'b11, 8'h00}, '{8'h29, 2'b01, 8'h20}, '{8'hE0, 2'b01, 8'h00},
      '{8'h5A, 2'b00, 8'h0D}, '{8'h0E, 2'b01, 8'h7E}, '{8'h45, 2'b01, 8'h29},
      '{8'h5D, 2'b00, 8'h5C}, '{8'h52, 2'b01, 8'h22}, '{8'h66, 2'b11, 8'h08},
      '{8'h49, 2'b00, 8'h2E}, '{8'h35, 2'b11, 8'h79}, '{8'h76, 2'b01, 8'h1B}
    };
    prev = 8'h00;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      key  = vecs[i].k;
      mode = vecs[i].m;
      #1;
      chk($sformatf("ascii hold %0d", i), ascii, prev);
      @(negedge clk);
      chk($sformatf("ascii key %h mode %b", vecs[i].k, vecs[i].m), ascii, vecs[i].exp);
      prev = vecs[i].exp;
    end

    send_frame(8'h1C, 1'b0, "frame 1C");
    pop_chk("pop 1C");
    chk("empty after pop", {7'd0, ready}, 8'd0);

    nextdata_n = 1'b0;
    repeat (2) @(negedge clk);
    nextdata_n = 1'b1;
    @(negedge clk);
    chk("pop while empty", {7'd0, ready}, 8'd0);

    send_frame(8'h1C, 1'b1, "bad parity 1C");
    send_frame(8'h32, 1'b0, "frame 32");
    pop_chk("pop 32");

    for (int c = 8'h15; c <= 8'h1C; c++)
      send_frame(8'(c), 1'b0, $sformatf("fill %h", c));
    chk("overflow set", {7'd0, overflow}, 8'd1);
    for (int i = 0; i < 7; i++) pop_chk($sformatf("drain %0d", i));
    @(negedge clk);
    chk("empty after drain", {7'd0, ready}, 8'd0);

    frame_samples = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    do_reset();
    chk("mid-frame reset ready", {7'd0, ready}, 8'd0);
    send_frame(8'h29, 1'b0, "frame 29 after reset");
    pop_chk("pop 29");
    @(negedge clk);
    chk("partial frame not stored", {7'd0, ready}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
